nios_ii_nios2_gen2_0_cpu_ocimem_arb: RTL and testbench

Arbiter and sequencer for the single-port on-chip debug memory (OCI RAM) inside the Nios II debug module. It shares the RAM between two requesters. One is the CPU-side Avalon debug memory slave. The other is the JTAG debug slave's sysclk-domain action strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a` with `jdo`). It latches the one-cycle JTAG strobes, maintains the auto-incrementing JTAG address, drives the RAM port, and returns read data to `MonDReg`.

---
 rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb_if.sv | 31 +++
 rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv | 127 ++++++++++++
 tb/tb_nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb_if.sv
// rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb_if.sv - Avalon debug slave and OCI RAM port bundle
interface nios_ii_nios2_gen2_0_cpu_ocimem_arb_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_byteenable;
  logic              ram_wren;
  logic [31:0]       ram_rdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest,
    output ram_addr, ram_wdata, ram_byteenable, ram_wren,
    input  ram_rdata
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest,
    input  ram_addr, ram_wdata, ram_byteenable, ram_wren,
    output ram_rdata
  );
endinterface

// File: rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv
// rtl/nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv - OCI RAM arbiter for Avalon and JTAG; OCIMEM_AVS_WP_EN enables Avalon write protect
module nios_ii_nios2_gen2_0_cpu_ocimem_arb #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [37:0] jdo,
  output logic [31:0] MonDReg,
  output logic        jtag_idle,
  output logic        jtag_overrun,
  output logic        wp_hit,
  nios_ii_nios2_gen2_0_cpu_ocimem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_AV, RD_JT} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              jpend, jwrite, last_grant_jt;
  logic [31:0]       jwdata;
  logic [ADDR_W-1:0] jaddr;
  logic              av_req, av_prot, grant_av, grant_jt, tie;
  logic              any_strobe, multi_strobe, can_accept, accept, dropped;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  assign av_req       = bus.avs_read | bus.avs_write;
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
  assign can_accept   = !jpend && (state != RD_JT);
  assign accept       = any_strobe && can_accept;
  assign dropped      = multi_strobe || (any_strobe && !can_accept);
  assign jtag_idle    = can_accept;
  assign tie          = (state == IDLE) && av_req && jpend;

`ifdef OCIMEM_AVS_WP_EN
  // Lower half of the RAM holds the debug ROM image
  assign av_prot = !bus.avs_address[ADDR_W-1];
`else
  assign av_prot = 1'b0;
`endif

  always_comb begin
    state_nxt           = state;
    grant_av            = 1'b0;
    grant_jt            = 1'b0;
    bus.avs_waitrequest = 1'b1;
    bus.avs_readdata    = 32'h0;
    bus.ram_addr        = jaddr;
    bus.ram_wdata       = jwdata;
    bus.ram_byteenable  = 4'hF;
    bus.ram_wren        = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the winner is whoever lost the previous tie
        if (av_req && (!jpend || last_grant_jt)) grant_av = 1'b1;
        else if (jpend)                          grant_jt = 1'b1;
        if (grant_av) begin
          bus.ram_addr       = bus.avs_address;
          bus.ram_wdata      = bus.avs_writedata;
          bus.ram_byteenable = bus.avs_byteenable;
          if (bus.avs_write) begin
            bus.avs_waitrequest = 1'b0;
            bus.ram_wren        = !av_prot;
          end else begin
            state_nxt = RD_AV;
          end
        end else if (grant_jt) begin
          if (jwrite) bus.ram_wren = 1'b1;
          else        state_nxt    = RD_JT;
        end
      end
      RD_AV: begin
        bus.avs_waitrequest = 1'b0;
        bus.avs_readdata    = bus.ram_rdata;
        state_nxt           = IDLE;
      end
      RD_JT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      jpend         <= 1'b0;
      jwrite        <= 1'b0;
      jwdata        <= 32'h0;
      jaddr         <= '0;
      last_grant_jt <= 1'b0;
      MonDReg       <= 32'h0;
      jtag_overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tie) last_grant_jt <= grant_jt;
      if (grant_jt) jpend <= 1'b0;
      if ((grant_jt && jwrite) || state == RD_JT) jaddr <= jaddr + ADDR_ONE;
      if (state == RD_JT) MonDReg <= bus.ram_rdata;
      // Acceptance excludes every cycle that moves jaddr, so the load never collides
      if (accept) begin
        jpend  <= 1'b1;
        jwrite <= !take_action_ocimem_a && take_action_ocimem_b;
        jwdata <= jdo[34:3];
        if (take_action_ocimem_a) jaddr <= jdo[ADDR_W+1:2];
      end
      if (dropped)                           jtag_overrun <= 1'b1;
      else if (accept && take_action_ocimem_a) jtag_overrun <= 1'b0;
    end
  end

`ifdef OCIMEM_AVS_WP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       wp_hit <= 1'b0;
    else if (grant_av && bus.avs_write && av_prot)   wp_hit <= 1'b1;
  end
`else
  assign wp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv
// tb/tb_nios_ii_nios2_gen2_0_cpu_ocimem_arb.sv - self-checking bench for the OCI RAM arbiter
module tb_nios_ii_nios2_gen2_0_cpu_ocimem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_a = 1'b0, s_b = 1'b0, s_n = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic        jtag_idle, jtag_overrun, wp_hit;

  int n_checks = 0;
  int n_fail   = 0;

  nios_ii_nios2_gen2_0_cpu_ocimem_arb_if #(.ADDR_W(8)) bus ();

  nios_ii_nios2_gen2_0_cpu_ocimem_arb #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (rst),
    .take_action_ocimem_a    (s_a),
    .take_no_action_ocimem_a (s_n),
    .take_action_ocimem_b    (s_b),
    .jdo                     (jdo),
    .MonDReg                 (MonDReg),
    .jtag_idle               (jtag_idle),
    .jtag_overrun            (jtag_overrun),
    .wp_hit                  (wp_hit),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, b};
  endfunction

  function automatic logic [37:0] jd_addr(input logic [7:0] a);
    return {28'h0, a, 2'b00};
  endfunction

  function automatic logic [37:0] jd_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Single-port RAM with registered read
  logic [31:0] mem [256];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_wren) begin
      for (int k = 0; k < 4; k++)
        if (bus.ram_byteenable[k]) mem[bus.ram_addr][8*k +: 8] <= bus.ram_wdata[8*k +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Reference: a pending JTAG job, a read in flight, and the port shared cycle by cycle
  logic [31:0] ref_mem [256];
  bit          ref_ready = 1'b0;
  bit          m_jp, m_jw, rr_valid, rr_to_jt, m_ovr, m_wp, m_turn_jt;
  logic [31:0] m_jd, m_mon;
  logic [7:0]  m_jaddr, rr_addr;

  always @(negedge clk) begin : cmp
    bit          av_req, jt_first, open, prot;
    bit          e_wait, e_wren, e_idle, e_ovr, e_wp;
    logic [31:0] e_rdata, e_wd, e_mon;
    logic [7:0]  e_addr;
    logic [3:0]  e_be;
    int          ns;
    if (rst) begin
      if (!ref_ready) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        ref_ready = 1'b1;
      end
      m_jp = 0; m_jw = 0; m_jd = 0; rr_valid = 0; rr_to_jt = 0; rr_addr = 0;
      m_jaddr = 0; m_mon = 0; m_ovr = 0; m_wp = 0; m_turn_jt = 1;
      chk("rst_waitrequest", bus.avs_waitrequest, 1);
      chk("rst_wren", bus.ram_wren, 0);
      chk("rst_readdata", bus.avs_readdata, 0);
      chk("rst_mondreg", MonDReg, 0);
      chk("rst_idle", jtag_idle, 1);
      chk("rst_overrun", jtag_overrun, 0);
      chk("rst_wp_hit", wp_hit, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
    end else begin
      av_req  = bus.avs_read | bus.avs_write;
      open    = !m_jp && !(rr_valid && rr_to_jt);
      e_idle  = open; e_mon = m_mon; e_ovr = m_ovr; e_wp = m_wp;
      e_wait  = 1; e_rdata = 0; e_wren = 0; e_addr = m_jaddr; e_wd = 0; e_be = 0;
      if (rr_valid) begin
        if (!rr_to_jt) begin
          e_wait  = 0;
          e_rdata = ref_mem[rr_addr];
        end else begin
          m_mon   = ref_mem[rr_addr];
          m_jaddr = m_jaddr + 8'd1;
        end
        rr_valid = 0;
      end else if (av_req || m_jp) begin
        jt_first = m_jp && (!av_req || m_turn_jt);
        if (av_req && m_jp) m_turn_jt = !jt_first;
        if (!jt_first) begin
          e_addr = bus.avs_address;
          if (bus.avs_write) begin
`ifdef OCIMEM_AVS_WP_EN
            prot = (bus.avs_address < 8'h80);
`else
            prot = 0;
`endif
            e_wait = 0;
            if (prot) m_wp = 1;
            else begin
              e_wren = 1; e_wd = bus.avs_writedata; e_be = bus.avs_byteenable;
              for (int k = 0; k < 4; k++)
                if (e_be[k]) ref_mem[e_addr][8*k +: 8] = e_wd[8*k +: 8];
            end
          end else begin
            rr_valid = 1; rr_to_jt = 0; rr_addr = bus.avs_address;
          end
        end else begin
          m_jp = 0;
          if (m_jw) begin
            e_wren = 1; e_wd = m_jd; e_be = 4'hF;
            ref_mem[m_jaddr] = m_jd;
            m_jaddr = m_jaddr + 8'd1;
          end else begin
            rr_valid = 1; rr_to_jt = 1; rr_addr = m_jaddr;
          end
        end
      end
      ns = int'(s_a) + int'(s_b) + int'(s_n);
      if (ns > 0) begin
        if (open) begin
          m_jp = 1;
          m_jw = !s_a && s_b;
          m_jd = jdo[34:3];
          if (s_a) begin m_jaddr = jdo[9:2]; m_ovr = 0; end
        end
        if (ns > 1 || !open) m_ovr = 1;
      end
      chk("waitrequest", bus.avs_waitrequest, e_wait);
      chk("readdata", bus.avs_readdata, e_rdata);
      chk("ram_wren", bus.ram_wren, e_wren);
      chk("ram_addr", bus.ram_addr, e_addr);
      chk("jtag_idle", jtag_idle, e_idle);
      chk("MonDReg", MonDReg, e_mon);
      chk("jtag_overrun", jtag_overrun, e_ovr);
      chk("wp_hit", wp_hit, e_wp);
      if (e_wren) begin
        chk("ram_wdata", bus.ram_wdata, e_wd);
        chk("ram_byteenable", bus.ram_byteenable, e_be);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit a, input bit b, input bit n, input logic [37:0] d);
    s_a = a; s_b = b; s_n = n; jdo = d;
    cyc();
    s_a = 0; s_b = 0; s_n = 0;
  endtask

  task automatic wait_jidle();
    int k = 0;
    @(negedge clk);
    while (!jtag_idle && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("jtag_idle_timeout", jtag_idle, 1);
    cyc();
  endtask

  task automatic av_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    bus.avs_address = a; bus.avs_write = wr; bus.avs_read = !wr;
    bus.avs_writedata = d; bus.avs_byteenable = be;
    lat = 0;
    @(negedge clk);
    while (bus.avs_waitrequest && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    rd = bus.avs_readdata;
    chk("avs_wait_timeout", bus.avs_waitrequest, 0);
    cyc();
    bus.avs_read = 0; bus.avs_write = 0;
  endtask

  initial begin
    int          lat, age;
    logic [31:0] rd;
    bit          av_act, av_done;
    bus.avs_address = 0; bus.avs_read = 0; bus.avs_write = 0;
    bus.avs_writedata = 0; bus.avs_byteenable = 0;
    repeat (3) cyc();
    rst = 0;
    @(negedge clk);
    chk("post_reset_waitrequest", bus.avs_waitrequest, 1);
    chk("post_reset_idle", jtag_idle, 1);
    cyc();

    // JTAG burst across the top of the address space
    strobe(1, 0, 0, jd_addr(8'hFE));
    repeat (2) cyc();
    @(negedge clk);
    chk("burst_idle_n3", jtag_idle, 1);
    chk("burst_read_fe", MonDReg, 32'hA5FE01FE);
    cyc();
    strobe(0, 1, 0, jd_data(32'h11111111));
    repeat (3) cyc();
    strobe(0, 1, 0, jd_data(32'h22222222));
    repeat (3) cyc();
    chk("burst_mem_ff", mem[8'hFF], 32'h11111111);
    chk("burst_mem_00_wrap", mem[8'h00], 32'h22222222);

    // Reset on the JTAG write cycle
    strobe(1, 0, 0, jd_addr(8'h04));
    wait_jidle();
    s_b = 1; jdo = jd_data(32'hDEADBEEF);
    cyc();
    s_b = 0; rst = 1;
    repeat (2) cyc();
    rst = 0;
    @(negedge clk);
    chk("reset_mem_05", mem[8'h05], 32'hA505FA05);
    chk("reset_jaddr", bus.ram_addr, 0);
    chk("reset_idle", jtag_idle, 1);
    chk("reset_waitrequest", bus.avs_waitrequest, 1);
    cyc();

    // Tie: JTAG wins the first, Avalon the second
    strobe(0, 0, 1, jd_addr(8'h00));
    av_cmd(0, 8'h10, 0, 4'hF, lat, rd);
    chk("tie1_av_latency", lat, 3);
    chk("tie1_av_data", rd, 32'hA510EF10);
    wait_jidle();
    chk("tie1_jtag_data", MonDReg, 32'h22222222);
    strobe(0, 0, 1, jd_addr(8'h00));
    av_cmd(0, 8'h11, 0, 4'hF, lat, rd);
    chk("tie2_av_latency", lat, 1);
    chk("tie2_av_data", rd, 32'hA511EE11);
    wait_jidle();
    chk("tie2_jtag_data", MonDReg, 32'hA501FE01);

    // Overrun from back-to-back writes, cleared by ocimem_a
    s_b = 1; jdo = jd_data(32'h0BADF00D);
    repeat (2) cyc();
    s_b = 0;
    wait_jidle();
    chk("overrun_set", jtag_overrun, 1);
    chk("overrun_first_write", mem[8'h02], 32'h0BADF00D);
    strobe(1, 0, 0, jd_addr(8'h40));
    @(negedge clk);
    chk("overrun_cleared", jtag_overrun, 0);
    cyc();
    wait_jidle();
    chk("read_40", MonDReg, 32'hA540BF40);

    // Byte enables
    av_cmd(1, 8'hB0, 32'h0, 4'hF, lat, rd);
    chk("av_write_latency", lat, 0);
    av_cmd(1, 8'hB0, 32'hAABBCCDD, 4'b0101, lat, rd);
    av_cmd(0, 8'hB0, 0, 4'hF, lat, rd);
    chk("byteenable_readback", rd, 32'h00BB00DD);
    chk("av_read_latency", lat, 1);

    // Lower-half write: protected only when the feature is built in
    av_cmd(1, 8'h20, 32'h1234, 4'hF, lat, rd);
    repeat (2) cyc();
`ifdef OCIMEM_AVS_WP_EN
    chk("wp_mem_20", mem[8'h20], 32'hA520DF20);
    chk("wp_hit_set", wp_hit, 1);
    av_cmd(1, 8'h80, 32'h1234, 4'hF, lat, rd);
    repeat (2) cyc();
    chk("wp_mem_80", mem[8'h80], 32'h1234);
`else
    chk("nowp_mem_20", mem[8'h20], 32'h1234);
    chk("nowp_wp_hit", wp_hit, 0);
`endif

    // Randomized traffic against the reference
    av_act = 0; av_done = 0; age = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (av_done) begin
        bus.avs_read = 0; bus.avs_write = 0; av_act = 0; av_done = 0;
      end
      if (!av_act && $urandom_range(0, 2) == 0) begin
        bit wr;
        wr = 1'($urandom_range(0, 1));
        av_act = 1; age = 0;
        bus.avs_address = 8'($urandom); bus.avs_write = wr; bus.avs_read = !wr;
        bus.avs_writedata = $urandom; bus.avs_byteenable = 4'($urandom);
      end
      r = $urandom_range(0, 19);
      jdo = {6'($urandom), $urandom};
      s_a = (r == 0); s_b = (r == 1 || r == 3); s_n = (r == 2 || r == 3);
      @(negedge clk);
      if (av_act) begin
        if (!bus.avs_waitrequest) av_done = 1;
        else if (++age > 10) begin
          chk("avs_random_stall", bus.avs_waitrequest, 0);
          av_done = 1;
        end
      end
      cyc();
      s_a = 0; s_b = 0; s_n = 0;
    end
    bus.avs_read = 0; bus.avs_write = 0;
    repeat (6) cyc();
    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
